// File: rtl/imem_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_if
// Description : Bundles the PC register, instruction-memory and decode-side
//               signals seen by the fetch unit.
// Revision    : 1.0
// ============================================================================
interface imem_fetch_if;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;

    modport master (
        input  pc, redirect_valid, redirect_pc, imem_rvalid, imem_rdata, instr_ready,
        output next_pc, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err
    );

    modport slave (
        output pc, redirect_valid, redirect_pc, imem_rvalid, imem_rdata, instr_ready,
        input  next_pc, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch
// Description : Single-outstanding instruction fetch unit driving the PC
//               register's next_pc and a valid/ready decode handshake.
// Revision    : 1.0
// ============================================================================
module imem_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         reset,
    imem_fetch_if.master bus
);
    localparam logic [31:0] c_pc_step = 32'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_issue;
    logic        w_capture;
    logic        w_misaligned;
    logic [31:0] w_next_pc;

    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_fetch_err;

    assign w_misaligned = (bus.pc[1:0] != 2'b00);

    // A redirect in REQ still lets the aligned request go out, so it must be drained.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: w_state_next = S_REQ;
            S_REQ: begin
                if (w_misaligned) begin
                    w_state_next = bus.redirect_valid ? S_REQ : S_ERR;
                end else begin
                    w_issue      = 1'b1;
                    w_state_next = bus.redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    w_state_next = bus.imem_rvalid ? S_REQ : S_DRAIN;
                end else if (bus.imem_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.redirect_valid || bus.instr_ready) begin
                    w_state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (bus.imem_rvalid) begin
                    w_state_next = S_REQ;
                end
            end
            S_ERR: begin
                if (bus.redirect_valid) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_next_pc = bus.pc;
        if (!reset) begin
            w_next_pc = RESET_PC;
        end else if (bus.redirect_valid) begin
            w_next_pc = bus.redirect_pc;
        end else if ((r_state == S_WAIT) && bus.imem_rvalid) begin
            w_next_pc = bus.pc + c_pc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // instr_valid and fetch_err simply mirror occupancy of OUT and ERR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_imem_req    <= 1'b0;
            r_imem_addr   <= 32'h0;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_imem_req    <= w_issue;
            r_instr_valid <= (w_state_next == S_OUT);
            r_fetch_err   <= (w_state_next == S_ERR);
            if (w_issue) begin
                r_imem_addr <= bus.pc;
            end
            if (w_capture) begin
                r_instr    <= bus.imem_rdata;
                r_instr_pc <= bus.pc;
            end
        end
    end

    assign bus.next_pc     = w_next_pc;
    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_imem_addr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.fetch_err   = r_fetch_err;
endmodule
`default_nettype wire
